tft_frame_sequencer: RTL and testbench

Command sequencer that sits in front of the TFT SPI byte transmitter. After reset it plays a fixed initialization script into the transmitter. It then accepts rectangle-fill requests and turns each one into a column/row window setup, a RAMWR command and a stream of RGB565 pixel bytes. It is the only master of the transmitter's byte interface. The maze renderer issues requests to it.

---
 rtl/tft_pkg.sv | 30 +++
 rtl/tft_init_rom.sv | 27 ++
 rtl/tft_frame_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_tft_frame_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared opcodes, init ROM entry types and sequencer states
// for the TFT frame sequencer.
package tft_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam logic [1:0] ROM_CMD   = 2'b00;
  localparam logic [1:0] ROM_DATA  = 2'b01;
  localparam logic [1:0] ROM_DELAY = 2'b10;
  localparam logic [1:0] ROM_END   = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT_FETCH,
    ST_INIT_DELAY,
    ST_IDLE,
    ST_CHECK,
    ST_WIN,
    ST_PIX,
    ST_SEND,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/tft_init_rom.sv
// Panel power-up script as {type, value} entries.
// Anything past the last entry reads as end-of-script.
module tft_init_rom
  import tft_pkg::*;
(
  input  logic [3:0] idx,
  output logic [9:0] entry
);

  // Script lookup
  always_comb begin
    entry = {ROM_END, 8'h00};
    case (idx)
      4'd0:    entry = {ROM_CMD,   CMD_SWRESET};
      4'd1:    entry = {ROM_DELAY, 8'd3};
      4'd2:    entry = {ROM_CMD,   CMD_SLPOUT};
      4'd3:    entry = {ROM_DELAY, 8'd3};
      4'd4:    entry = {ROM_CMD,   CMD_COLMOD};
      4'd5:    entry = {ROM_DATA,  8'h55};
      4'd6:    entry = {ROM_CMD,   CMD_MADCTL};
      4'd7:    entry = {ROM_DATA,  8'h00};
      4'd8:    entry = {ROM_CMD,   CMD_DISPON};
      default: entry = {ROM_END,   8'h00};
    endcase
  end

endmodule

// File: rtl/tft_frame_sequencer.sv
// Plays the init script, then turns rectangle-fill requests
// into CASET/RASET/RAMWR plus RGB565 pixel bytes.
module tft_frame_sequencer
  import tft_pkg::*;
#(
  parameter int WIDTH      = 240,
  parameter int HEIGHT     = 320,
  parameter int DELAY_UNIT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [8:0]  req_x0,
  input  logic [8:0]  req_x1,
  input  logic [8:0]  req_y0,
  input  logic [8:0]  req_y1,
  input  logic [15:0] req_color,
  output logic [7:0]  spi_data,
  output logic        spi_dc,
  output logic        spi_transmit,
  input  logic        spi_busy,
  output logic        init_done,
  output logic        active,
  output logic        err
);

  localparam logic [9:0] XLIM = 10'(WIDTH);
  localparam logic [9:0] YLIM = 10'(HEIGHT);

  state_t      state, state_n;
  state_t      ret, ret_n;
  logic [3:0]  idx, idx_n;
  logic [31:0] dcnt, dcnt_n;
  logic [8:0]  x0, x0_n, x1, x1_n;
  logic [8:0]  y0, y0_n, y1, y1_n;
  logic [15:0] color, color_n;
  logic [3:0]  widx, widx_n;
  logic [16:0] count, count_n;
  logic        phase, phase_n;
  logic [7:0]  data, data_n;
  logic        dc, dc_n;
  logic        done, done_n;

  logic [9:0]  rom_entry;
  logic [1:0]  rom_type;
  logic [7:0]  rom_val;
  logic [7:0]  wbyte;
  logic [16:0] cols, rows;
  logic        bad;

  tft_init_rom u_rom (
    .idx   (idx),
    .entry (rom_entry)
  );

  assign rom_type = rom_entry[9:8];
  assign rom_val  = rom_entry[7:0];

  assign cols = 17'(x1) - 17'(x0) + 17'd1;
  assign rows = 17'(y1) - 17'(y0) + 17'd1;

  assign bad = (x0 > x1) || (y0 > y1) ||
               ({1'b0, x1} >= XLIM) ||
               ({1'b0, y1} >= YLIM);

  // Window setup byte for the current position
  always_comb begin
    wbyte = CMD_RAMWR;
    case (widx)
      4'd1:    wbyte = {7'd0, x0[8]};
      4'd2:    wbyte = x0[7:0];
      4'd3:    wbyte = {7'd0, x1[8]};
      4'd4:    wbyte = x1[7:0];
      4'd5:    wbyte = CMD_RASET;
      4'd6:    wbyte = {7'd0, y0[8]};
      4'd7:    wbyte = y0[7:0];
      4'd8:    wbyte = {7'd0, y1[8]};
      4'd9:    wbyte = y1[7:0];
      default: wbyte = CMD_RAMWR;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT_FETCH;
      ret   <= ST_INIT_FETCH;
      idx   <= '0;
      dcnt  <= '0;
      x0    <= '0;
      x1    <= '0;
      y0    <= '0;
      y1    <= '0;
      color <= '0;
      widx  <= '0;
      count <= '0;
      phase <= 1'b0;
      data  <= '0;
      dc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ret   <= ret_n;
      idx   <= idx_n;
      dcnt  <= dcnt_n;
      x0    <= x0_n;
      x1    <= x1_n;
      y0    <= y0_n;
      y1    <= y1_n;
      color <= color_n;
      widx  <= widx_n;
      count <= count_n;
      phase <= phase_n;
      data  <= data_n;
      dc    <= dc_n;
      done  <= done_n;
    end
  end

  // Next-state logic; byte sends go via SEND/WAIT and resume at ret
  always_comb begin
    state_n = state;
    ret_n   = ret;
    idx_n   = idx;
    dcnt_n  = dcnt;
    x0_n    = x0;
    x1_n    = x1;
    y0_n    = y0;
    y1_n    = y1;
    color_n = color;
    widx_n  = widx;
    count_n = count;
    phase_n = phase;
    data_n  = data;
    dc_n    = dc;
    done_n  = done;
    case (state)
      ST_INIT_FETCH: begin
        case (rom_type)
          ROM_CMD, ROM_DATA: begin
            data_n  = rom_val;
            dc_n    = (rom_type == ROM_DATA);
            idx_n   = idx + 4'd1;
            ret_n   = ST_INIT_FETCH;
            state_n = ST_SEND;
          end
          ROM_DELAY: begin
            dcnt_n  = 32'(rom_val) * 32'(DELAY_UNIT);
            idx_n   = idx + 4'd1;
            state_n = ST_INIT_DELAY;
          end
          default: begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        endcase
      end
      ST_INIT_DELAY: begin
        if (dcnt <= 32'd1) state_n = ST_INIT_FETCH;
        else dcnt_n = dcnt - 32'd1;
      end
      ST_IDLE: begin
        if (req_valid) begin
          x0_n    = req_x0;
          x1_n    = req_x1;
          y0_n    = req_y0;
          y1_n    = req_y1;
          color_n = req_color;
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bad) begin
          state_n = ST_IDLE;
        end else begin
          data_n  = CMD_CASET;
          dc_n    = 1'b0;
          widx_n  = 4'd1;
          ret_n   = ST_WIN;
          state_n = ST_SEND;
        end
      end
      ST_WIN: begin
        data_n  = wbyte;
        dc_n    = (widx != 4'd5) && (widx != 4'd10);
        widx_n  = widx + 4'd1;
        ret_n   = ST_WIN;
        state_n = ST_SEND;
        if (widx == 4'd10) begin
          count_n = cols * rows;
          phase_n = 1'b0;
          ret_n   = ST_PIX;
        end
      end
      ST_PIX: begin
        if (count == 17'd0) begin
          state_n = ST_IDLE;
        end else begin
          dc_n    = 1'b1;
          ret_n   = ST_PIX;
          state_n = ST_SEND;
          if (!phase) begin
            data_n  = color[15:8];
            phase_n = 1'b1;
          end else begin
            data_n  = color[7:0];
            phase_n = 1'b0;
            count_n = count - 17'd1;
          end
        end
      end
      ST_SEND: begin
        if (!spi_busy) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (!spi_busy) state_n = ret;
      end
      default: state_n = ST_INIT_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    spi_data     = data;
    spi_dc       = dc;
    init_done    = done;
    spi_transmit = !rst && (state == ST_SEND) && !spi_busy;
    req_ready    = !rst && (state == ST_IDLE);
    err          = !rst && (state == ST_CHECK) && bad;
    active       = !rst && (
                     (state == ST_WIN) || (state == ST_PIX) ||
                     (((state == ST_SEND) || (state == ST_WAIT)) &&
                      ((ret == ST_WIN) || (ret == ST_PIX))));
  end

endmodule

// File: tb/tb_tft_frame_sequencer.sv
// Bench for tft_frame_sequencer: byte-stream model on a
// small panel with a transmitter busy 8 cycles per strobe.
module tb_tft_frame_sequencer;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int DU = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [8:0]  req_x0 = '0, req_x1 = '0;
  logic [8:0]  req_y0 = '0, req_y1 = '0;
  logic [15:0] req_color = '0;
  logic [7:0]  spi_data;
  logic        spi_dc;
  logic        spi_transmit;
  logic        spi_busy;
  logic        init_done;
  logic        active;
  logic        err;

  always #5 clk = ~clk;

  tft_frame_sequencer #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .DELAY_UNIT (DU)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x0       (req_x0),
    .req_x1       (req_x1),
    .req_y0       (req_y0),
    .req_y1       (req_y1),
    .req_color    (req_color),
    .spi_data     (spi_data),
    .spi_dc       (spi_dc),
    .spi_transmit (spi_transmit),
    .spi_busy     (spi_busy),
    .init_done    (init_done),
    .active       (active),
    .err          (err)
  );

  int bcnt = 0;
  always @(posedge clk) begin
    if (spi_transmit) bcnt <= 8;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign spi_busy = (bcnt != 0);

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  longint     stb_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Compare every strobe against the expected byte stream
  always @(negedge clk) begin
    if (rst) begin
      chk("tx_during_rst", 32'(spi_transmit), 32'd0);
    end else if (spi_transmit) begin
      chk("busy_at_strobe", 32'(spi_busy), 32'd0);
      got_q.push_back({spi_dc, spi_data});
      stb_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_strobe: got %h expected none",
                 {spi_dc, spi_data});
      end else begin
        chk("byte", 32'({spi_dc, spi_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_init();
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h03A);
    exp_q.push_back(9'h155);
    exp_q.push_back(9'h036);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h029);
  endtask

  task automatic push_fill(int x0, int x1, int y0, int y1,
                           logic [15:0] c);
    int n;
    exp_q.push_back(9'h02A);
    exp_q.push_back({1'b1, 8'(x0 / 256)});
    exp_q.push_back({1'b1, 8'(x0 % 256)});
    exp_q.push_back({1'b1, 8'(x1 / 256)});
    exp_q.push_back({1'b1, 8'(x1 % 256)});
    exp_q.push_back(9'h02B);
    exp_q.push_back({1'b1, 8'(y0 / 256)});
    exp_q.push_back({1'b1, 8'(y0 % 256)});
    exp_q.push_back({1'b1, 8'(y1 / 256)});
    exp_q.push_back({1'b1, 8'(y1 % 256)});
    exp_q.push_back(9'h02C);
    n = (x1 - x0 + 1) * (y1 - y0 + 1);
    for (int p = 0; p < n; p++) begin
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(string n, int lim);
    for (int i = 0; i < lim && exp_q.size() != 0; i++) tick();
    chk(n, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ready(string n, int lim);
    for (int i = 0; i < lim && !req_ready; i++) tick();
    chk(n, 32'(req_ready), 32'd1);
  endtask

  task automatic request(int x0, int x1, int y0, int y1,
                         logic [15:0] c);
    wait_ready("ready_before_req", 500);
    req_x0    = 9'(x0);
    req_x1    = 9'(x1);
    req_y0    = 9'(y0);
    req_y1    = 9'(y1);
    req_color = c;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic reject(string n, int x0, int x1, int y0, int y1);
    got_q.delete();
    request(x0, x1, y0, y1, 16'hFFFF);
    chk({n, "_err"}, 32'(err), 32'd1);
    chk({n, "_ready_low"}, 32'(req_ready), 32'd0);
    tick();
    chk({n, "_err_once"}, 32'(err), 32'd0);
    chk({n, "_ready_back"}, 32'(req_ready), 32'd1);
    repeat (5) tick();
    chk({n, "_no_strobe"}, 32'(got_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(string n);
    chk({n, "_data"}, 32'(spi_data), 32'd0);
    chk({n, "_dc"}, 32'(spi_dc), 32'd0);
    chk({n, "_ready"}, 32'(req_ready), 32'd0);
    chk({n, "_done"}, 32'(init_done), 32'd0);
    chk({n, "_active"}, 32'(active), 32'd0);
    chk({n, "_err"}, 32'(err), 32'd0);
  endtask

  logic [8:0] init_lit [7] = '{9'h001, 9'h011, 9'h03A, 9'h155,
                               9'h036, 9'h100, 9'h029};
  logic [8:0] fill_lit [15] = '{9'h02A, 9'h100, 9'h10A, 9'h100,
                                9'h10B, 9'h02B, 9'h100, 9'h105,
                                9'h100, 9'h105, 9'h02C, 9'h1F8,
                                9'h100, 9'h1F8, 9'h100};
  int     k2c;
  int     nd;
  longint gap;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check_reset_vals("rst0");
    got_q.delete();
    stb_t.delete();
    push_init();
    rst = 1'b0;

    for (int i = 0; i < 100 && got_q.size() == 0; i++) tick();
    chk("ready_during_init", 32'(req_ready), 32'd0);
    chk("done_during_init", 32'(init_done), 32'd0);
    wait_drain("init_drain", 3000);
    chk("done_at_dispon", 32'(init_done), 32'd0);
    for (int i = 0; i < 100 && !init_done; i++) tick();
    chk("init_done", 32'(init_done), 32'd1);
    chk("ready_after_init", 32'(req_ready), 32'd1);
    chk("init_len", 32'(got_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < got_q.size(); i++)
      chk("init_lit", 32'(got_q[i]), 32'(init_lit[i]));
    if (stb_t.size() >= 3) begin
      gap = stb_t[1] - stb_t[0];
      chk("gap_swreset_min", 32'(gap >= 3 * DU), 32'd1);
      chk("gap_swreset_max", 32'(gap <= 3 * DU + 20), 32'd1);
      gap = stb_t[2] - stb_t[1];
      chk("gap_slpout_min", 32'(gap >= 3 * DU), 32'd1);
      chk("gap_slpout_max", 32'(gap <= 3 * DU + 20), 32'd1);
    end else begin
      chk("init_strobe_count", 32'(stb_t.size()), 32'd7);
    end

    got_q.delete();
    push_fill(10, 11, 5, 5, 16'hF800);
    chk("model_small_len", 32'(exp_q.size()), 32'd15);
    request(10, 11, 5, 5, 16'hF800);
    chk("valid_no_err", 32'(err), 32'd0);
    tick();
    chk("first_win_strobe", 32'(spi_transmit), 32'd1);
    chk("active_in_win", 32'(active), 32'd1);
    wait_drain("fill1_drain", 1000);
    chk("active_last_byte", 32'(active), 32'd1);
    wait_ready("fill1_ready", 100);
    chk("active_after", 32'(active), 32'd0);
    chk("fill1_len", 32'(got_q.size()), 32'd15);
    for (int i = 0; i < 15 && i < got_q.size(); i++)
      chk("fill1_lit", 32'(got_q[i]), 32'(fill_lit[i]));

    reject("x_swapped", 20, 10, 0, 0);
    reject("y1_320", 0, 0, 0, 320);
    reject("y1_height", 0, 0, 0, H);
    reject("x1_width", 0, W, 0, 0);

    got_q.delete();
    push_fill(0, W - 1, 0, H - 1, 16'h1234);
    chk("model_full_len", 32'(exp_q.size()), 32'd395);
    request(0, W - 1, 0, H - 1, 16'h1234);
    wait_drain("full_drain", 20000);
    wait_ready("full_ready", 100);
    k2c = -1;
    nd = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] == 9'h02C && k2c < 0) k2c = i;
    for (int i = k2c + 1; k2c >= 0 && i < got_q.size(); i++)
      if (got_q[i][8]) nd++;
    chk("full_data_bytes", 32'(nd), 32'd384);

    push_fill(0, W - 1, 0, H - 1, 16'h07E0);
    request(0, W - 1, 0, H - 1, 16'h07E0);
    for (int i = 0; i < 5000 && exp_q.size() > 300; i++) tick();
    chk("mid_stream_active", 32'(active), 32'd1);
    rst = 1'b1;
    repeat (3) tick();
    check_reset_vals("rst1");
    exp_q.delete();
    got_q.delete();
    push_init();
    rst = 1'b0;
    wait_drain("restart_drain", 3000);
    chk("restart_first",
        32'(got_q.size() > 0 ? got_q[0] : 9'h1FF), 32'h001);
    for (int i = 0; i < 100 && !init_done; i++) tick();
    chk("restart_done", 32'(init_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
